// File: rtl/row_fetch_ctrl_if.sv
`timescale 1ns/1ps
// Burst-read bus between row_fetch_ctrl (master) and the SDRAM read port (slave).
interface row_fetch_ctrl_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    modport master (
        output rd_req, rd_addr,
        input  rd_gnt, rd_data, rd_data_valid
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_gnt, rd_data, rd_data_valid
    );
endinterface

// File: rtl/row_fetch_ctrl.sv
`timescale 1ns/1ps
// row_fetch_ctrl: accepts row requests, burst-reads the row from SDRAM into a ping-pong line buffer.
// Optional macro BLANK_ON_INVALID_EN blanks the display and drops new requests while valid=0.
module row_fetch_ctrl #(
    parameter int IMG_HEIGHT = 64,
    parameter int ROW_WORDS  = 32,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 24,
    localparam int ROW_W     = $clog2(IMG_HEIGHT),
    localparam int WORD_W    = $clog2(ROW_WORDS)
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [ROW_W-1:0]    row,
    input  logic                valid,
    input  logic                index,
    input  logic                rowChange,
    output logic                rowChangeAck,
    input  logic [ADDR_W-1:0]   frame_base,
    row_fetch_ctrl_if.master    rd,
    input  logic [WORD_W-1:0]   disp_addr,
    output logic [DATA_W-1:0]   disp_data,
    output logic [ROW_W-1:0]    disp_row,
    output logic                row_ready,
    output logic                overrun
);

    typedef enum logic [1:0] {IDLE, REQ, RECV, SWAP} state_t;

    state_t              state, state_nxt;
    logic                held, pend, buf_sel;
    logic [ROW_W-1:0]    pend_row, fetch_row;
    logic [ADDR_W-1:0]   latched_base;
    logic [WORD_W-1:0]   word_cnt;
    logic [DATA_W-1:0]   line_mem [0:2*ROW_WORDS-1];

    logic take, accept, swap_en, load, grant, beat, do_swap;

    // One ack per assertion of rowChange, even if the requester holds it past the ack.
    assign take = rowChange && !rowChangeAck && !held;

`ifdef BLANK_ON_INVALID_EN
    assign accept  = take && valid;
    assign swap_en = valid;
`else
    logic unused_valid;
    assign unused_valid = valid;
    assign accept  = take;
    assign swap_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        grant     = 1'b0;
        beat      = 1'b0;
        do_swap   = 1'b0;
        case (state)
            IDLE: if (pend) begin
                load      = 1'b1;
                state_nxt = REQ;
            end
            REQ: if (rd.rd_gnt) begin
                grant     = 1'b1;
                state_nxt = RECV;
            end
            RECV: if (rd.rd_data_valid) begin
                beat = 1'b1;
                if (word_cnt == WORD_W'(ROW_WORDS - 1)) state_nxt = SWAP;
            end
            SWAP: begin
                do_swap   = swap_en;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign row_ready = do_swap;

    // A request replacing one that is being loaded this same cycle is not an overrun.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rowChangeAck <= 1'b0;
            held         <= 1'b0;
            pend         <= 1'b0;
            pend_row     <= '0;
            overrun      <= 1'b0;
        end else begin
            rowChangeAck <= take;
            held         <= rowChange && (held || rowChangeAck);
            if (accept) begin
                pend_row <= row;
                pend     <= 1'b1;
                if (pend && !load) overrun <= 1'b1;
            end else if (load) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            latched_base <= '0;
            rd.rd_req    <= 1'b0;
            rd.rd_addr   <= '0;
            fetch_row    <= '0;
            word_cnt     <= '0;
            buf_sel      <= 1'b0;
            disp_row     <= '0;
        end else begin
            if (index) latched_base <= frame_base;
            if (load) begin
                rd.rd_req  <= 1'b1;
                rd.rd_addr <= latched_base + (ADDR_W'(pend_row) << WORD_W);
                fetch_row  <= pend_row;
            end
            if (grant) begin
                rd.rd_req <= 1'b0;
                word_cnt  <= '0;
            end
            if (beat) word_cnt <= word_cnt + WORD_W'(1);
            if (do_swap) begin
                buf_sel  <= ~buf_sel;
                disp_row <= fetch_row;
            end
        end
    end

    // The back half is the one not selected for display.
    always_ff @(posedge clk) begin
        if (beat) line_mem[{~buf_sel, word_cnt}] <= rd.rd_data;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            disp_data <= '0;
        end else begin
`ifdef BLANK_ON_INVALID_EN
            disp_data <= valid ? line_mem[{buf_sel, disp_addr}] : '0;
`else
            disp_data <= line_mem[{buf_sel, disp_addr}];
`endif
        end
    end

endmodule

// File: tb/tb_row_fetch_ctrl.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for row_fetch_ctrl: expected fetches are queued by the driver,
// a negedge monitor pops them on each new rd_req and tracks the displayed row's contents.
module tb_row_fetch_ctrl;
    localparam int IMG_HEIGHT = 64;
    localparam int ROW_WORDS  = 32;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 24;

    typedef struct packed {
        logic [5:0]  row;
        logic [23:0] addr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        nReset;
    logic [5:0]  row;
    logic        valid, index, rowChange, rowChangeAck;
    logic [23:0] frame_base;
    logic [4:0]  disp_addr;
    logic [15:0] disp_data;
    logic [5:0]  disp_row;
    logic        row_ready, overrun;

    row_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rd_bus ();

    row_fetch_ctrl #(
        .IMG_HEIGHT(IMG_HEIGHT), .ROW_WORDS(ROW_WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .nReset(nReset), .row(row), .valid(valid), .index(index),
        .rowChange(rowChange), .rowChangeAck(rowChangeAck), .frame_base(frame_base),
        .rd(rd_bus), .disp_addr(disp_addr), .disp_data(disp_data), .disp_row(disp_row),
        .row_ready(row_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          grant_dly = 1;
    int          beat_cnt = 0;
    fetch_t      exp_q[$];
    fetch_t      inflight;
    bit          have_inflight = 0;
    logic [23:0] model_base = '0;
    bit          exp_overrun = 0;
    logic [23:0] front_addr = '0;
    bit          front_known = 0;
    bit          pair_known = 0;
    bit          pair_blank = 0;
    logic [23:0] pair_addr = '0;
    bit          row_chk_pending = 0;
    logic [5:0]  row_chk_val = '0;
    bit          prev_req = 0, prev_ack = 0;
    logic [23:0] prev_addr = '0;

    // Memory contents are a fixed scramble of the word address.
    function automatic logic [15:0] data_of(input logic [23:0] a);
        logic [15:0] p;
        p = a[15:0] * 16'd37;
        return p ^ {a[23:16], 8'h5A};
    endfunction

    function automatic logic [23:0] addr_of(input int r);
        return model_base + 24'(r * ROW_WORDS);
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pushFetch(input int r, input logic [23:0] a);
        fetch_t e;
        e.row  = 6'(r);
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic setBase(input logic [23:0] b);
        @(posedge clk); #1;
        frame_base = b;
        index = 1'b1;
        @(posedge clk); #1;
        index = 1'b0;
        model_base = b;
    endtask

    // Raise rowChange for 'hold' cycles and require exactly one ack cycle.
    task automatic applyStimulus(input int r, input int hold);
        int acks;
        @(posedge clk); #1;
        row = 6'(r);
        rowChange = 1'b1;
        acks = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rowChangeAck) acks++;
            @(posedge clk); #1;
        end
        rowChange = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rowChangeAck) acks++;
        end
        checkOutput("ack_count", 32'(acks), 32'd1);
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !have_inflight && !rd_bus.rd_req) done = 1;
        end
        checkOutput("wait_idle_done", 32'(done), 32'd1);
        repeat (4) @(posedge clk);
    endtask

    // First request fetches alone; up to three more arrive mid-burst and only the last survives.
    task automatic burstRound(input int r0, input int n, input int r1, input int r2, input int r3,
                              input bit new_base);
        bit popped = 0;
        int last;
        pushFetch(r0, addr_of(r0));
        applyStimulus(r0, 2);
        for (int i = 0; i < 200 && !popped; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) popped = 1;
        end
        checkOutput("burst_started", 32'(popped), 32'd1);
        if (new_base) setBase(24'($urandom));
        applyStimulus(r1, $urandom_range(2, 3));
        last = r1;
        if (n > 1) begin applyStimulus(r2, 2); last = r2; end
        if (n > 2) begin applyStimulus(r3, 2); last = r3; end
        pushFetch(last, addr_of(last));
        if (n > 1) exp_overrun = 1;
        waitIdle();
        checkOutput("overrun", 32'(overrun), 32'(exp_overrun));
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            disp_addr = 5'($urandom_range(0, ROW_WORDS - 1));
        end
    end

    // SDRAM model: grants after grant_dly cycles, then streams a row with random gaps.
    initial begin
        logic [23:0] mem_addr;
        rd_bus.rd_gnt = 1'b0;
        rd_bus.rd_data_valid = 1'b0;
        rd_bus.rd_data = '0;
        forever begin
            @(negedge clk);
            if (rd_bus.rd_req === 1'b1) begin
                repeat (grant_dly) @(posedge clk);
                @(posedge clk); #1;
                mem_addr = rd_bus.rd_addr;
                rd_bus.rd_gnt = 1'b1;
                beat_cnt = 0;
                @(posedge clk); #1;
                rd_bus.rd_gnt = 1'b0;
                for (int i = 0; i < ROW_WORDS; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    rd_bus.rd_data = data_of(mem_addr + 24'(i));
                    rd_bus.rd_data_valid = 1'b1;
                    @(posedge clk); #1;
                    rd_bus.rd_data_valid = 1'b0;
                    beat_cnt++;
                end
            end
        end
    end

    // Monitor: pops expectations on each new rd_req, follows swaps to know the front row.
    initial begin
        fetch_t e;
        forever begin
            @(negedge clk);
            if (!nReset) begin
                pair_known = 0;
                front_known = 0;
                have_inflight = 0;
                row_chk_pending = 0;
                prev_req = 0;
                prev_ack = 0;
            end else begin
                if (pair_known)
                    checkOutput("disp_data", 32'(disp_data), pair_blank ? 32'd0 : 32'(data_of(pair_addr)));
                if (row_chk_pending) begin
                    checkOutput("disp_row", 32'(disp_row), 32'(row_chk_val));
                    row_chk_pending = 0;
                end
                if (rowChangeAck) checkOutput("ack_not_back_to_back", 32'(prev_ack), 32'd0);
                if (rd_bus.rd_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_fetch: got rd_addr 0x%0h expected no request", rd_bus.rd_addr);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rd_addr", 32'(rd_bus.rd_addr), 32'(e.addr));
                        inflight = e;
                        have_inflight = 1;
                    end
                end
                if (rd_bus.rd_req && prev_req)
                    checkOutput("rd_addr_stable", 32'(rd_bus.rd_addr), 32'(prev_addr));
                pair_known = front_known;
                pair_addr  = front_addr + 24'(disp_addr);
                pair_blank = !valid;
                if (row_ready) begin
                    if (!have_inflight) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_row_ready: got pulse expected none");
                    end else begin
                        row_chk_pending = 1;
                        row_chk_val = inflight.row;
                        front_addr = inflight.addr;
                        front_known = 1;
                        have_inflight = 0;
                    end
                end
                prev_req  = rd_bus.rd_req;
                prev_addr = rd_bus.rd_addr;
                prev_ack  = rowChangeAck;
            end
        end
    end

    initial begin
        bit reached;
        int r;
        nReset = 1'b0;
        row = '0;
        valid = 1'b1;
        index = 1'b0;
        rowChange = 1'b0;
        frame_base = '0;
        disp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ack", 32'(rowChangeAck), 32'd0);
        checkOutput("reset_rd_req", 32'(rd_bus.rd_req), 32'd0);
        checkOutput("reset_rd_addr", 32'(rd_bus.rd_addr), 32'd0);
        checkOutput("reset_row_ready", 32'(row_ready), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_disp_row", 32'(disp_row), 32'd0);
        checkOutput("reset_disp_data", 32'(disp_data), 32'd0);
        @(negedge clk);
        nReset = 1'b1;

        setBase(24'h001000);
        grant_dly = 1;
        pushFetch(3, 24'h001060);
        applyStimulus(3, 2);
        waitIdle();

        pushFetch(10, addr_of(10));
        applyStimulus(10, 4);
        waitIdle();
        checkOutput("overrun_clear", 32'(overrun), 32'd0);

        grant_dly = 2;
        burstRound(6, 3, 7, 8, 9, 0);

        setBase(24'hFFFFF0);
        grant_dly = 6;
        pushFetch(63, 24'h0007D0);
        applyStimulus(63, 2);
        waitIdle();

        for (int k = 0; k < 12; k++) begin
            grant_dly = $urandom_range(0, 6);
            if ($urandom_range(0, 2) == 0) setBase(24'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, IMG_HEIGHT - 1);
                pushFetch(r, addr_of(r));
                applyStimulus(r, $urandom_range(2, 4));
                waitIdle();
                checkOutput("overrun", 32'(overrun), 32'(exp_overrun));
            end else begin
                burstRound($urandom_range(0, 63), $urandom_range(1, 3), $urandom_range(0, 63),
                           $urandom_range(0, 63), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
            end
        end

        // Abandon a burst part-way; stale beats that keep arriving must be ignored.
        grant_dly = 2;
        pushFetch(20, addr_of(20));
        applyStimulus(20, 2);
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk);
            if (beat_cnt >= 10) reached = 1;
        end
        checkOutput("reached_ten_beats", 32'(reached), 32'd1);
        #2;
        nReset = 1'b0;
        exp_q.delete();
        exp_overrun = 0;
        model_base = '0;
        #1;
        checkOutput("midreset_rd_req", 32'(rd_bus.rd_req), 32'd0);
        checkOutput("midreset_rd_addr", 32'(rd_bus.rd_addr), 32'd0);
        checkOutput("midreset_overrun", 32'(overrun), 32'd0);
        checkOutput("midreset_disp_row", 32'(disp_row), 32'd0);
        checkOutput("midreset_disp_data", 32'(disp_data), 32'd0);
        checkOutput("midreset_row_ready", 32'(row_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nReset = 1'b1;
        pushFetch(5, 24'h0000A0);
        applyStimulus(5, 2);
        waitIdle();
        checkOutput("overrun_after_reset", 32'(overrun), 32'd0);

`ifdef BLANK_ON_INVALID_EN
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (4) @(posedge clk);
        applyStimulus(2, 2);
        repeat (80) @(posedge clk);
        checkOutput("blank_no_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        valid = 1'b1;
        repeat (6) @(posedge clk);
`endif

        repeat (4) @(posedge clk);
        checkOutput("no_leftover_fetch", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_fetch_ctrl.md
Name: row_fetch_ctrl

Overview:
Downstream consumer of the turn timer's row stream. On each row-change request it acknowledges the request, computes the SDRAM address of that image row, and issues a burst read. It fills the back half of an internal ping-pong line buffer and swaps halves when the row is complete. The LED column driver reads the front half through a synchronous read port.

Parameters:
IMG_HEIGHT, 64, rows per image; row input width is $clog2(IMG_HEIGHT)
ROW_WORDS, 32, words per row; power of two, at least 2
DATA_W, 16, SDRAM and line-buffer word width
ADDR_W, 24, SDRAM word-address width

Ports:
clk  in  1  system clock (SDRAM clock domain)
nReset  in  1  asynchronous active-low reset
row  in  $clog2(IMG_HEIGHT)  requested row from the turn timer
valid  in  1  turn-timer lock indicator
index  in  1  one-cycle pulse at the start of a revolution
rowChange  in  1  row-change request; held high until acknowledged
rowChangeAck  out  1  one-cycle acknowledge of rowChange
frame_base  in  ADDR_W  base address of the current frame; sampled on index
rd_req  out  1  burst read request
rd_addr  out  ADDR_W  burst start address
rd_gnt  in  1  memory accepted the request (one-cycle)
rd_data  in  DATA_W  returned read data
rd_data_valid  in  1  rd_data qualifier
disp_addr  in  $clog2(ROW_WORDS)  display read address
disp_data  out  DATA_W  front-buffer word; 1-cycle read latency
disp_row  out  $clog2(IMG_HEIGHT)  row currently held in the front buffer
row_ready  out  1  one-cycle pulse when the buffers swap
overrun  out  1  sticky flag: a request was replaced before it was fetched

Behaviour:
- Reset values (asynchronous):
  - rowChangeAck, rd_req, row_ready, overrun = 0
  - rd_addr, disp_row = 0
  - buffer select = 0, latched base = 0, state = IDLE, pending flag = 0
  - disp_data = 0 until the first registered read after reset
- Request intake:
  - When rowChange=1 and rowChangeAck was 0 in the previous cycle: pulse rowChangeAck for exactly one cycle and latch row into pend_row.
  - Set the pending flag in the same cycle.
  - Never assert rowChangeAck on two consecutive cycles.
  - If the pending flag is already set when a new request is latched: overwrite pend_row and set overrun. Overrun stays set until reset.
- Base latch: on index=1, latched_base <= frame_base. It takes effect for the next address computed, never mid-burst.
- Address rule: rd_addr = latched_base + pend_row * ROW_WORDS. Implement the multiply as a left shift; the result wraps modulo 2^ADDR_W.
- FSM:
  - IDLE: when the pending flag is set, load rd_addr, copy pend_row to fetch_row, clear the pending flag, assert rd_req, go to REQ.
  - REQ: hold rd_req and rd_addr stable until rd_gnt=1. On rd_gnt: drop rd_req in the next cycle, clear the word counter, go to RECV.
  - RECV: each rd_data_valid writes rd_data to back_buf[word_cnt] and increments word_cnt. The write of word ROW_WORDS-1 goes to SWAP. rd_data_valid outside RECV is ignored.
  - SWAP (one cycle): toggle buffer select, disp_row <= fetch_row, pulse row_ready, go to IDLE.
- Back-to-back requests: a pending request arriving during REQ or RECV is serviced immediately after SWAP. Minimum IDLE dwell is 1 cycle.
- Display port: disp_data <= front_buf[disp_addr] every cycle, registered. A swap takes effect on the read issued in the cycle after row_ready.
- Simultaneous events: an intake and a SWAP in the same cycle are both honoured; the new request is serviced next.
- index coinciding with the IDLE->REQ load uses the old base.
- Reset mid-burst abandons the burst. Late rd_data_valid after reset is ignored because the state is IDLE.

Optional Feature:
BLANK_ON_INVALID_EN
- Defined: while valid=0, disp_data is forced to 0 and new intakes are acknowledged but discarded (pending flag not set). Buffer contents are preserved. A burst already in flight completes but does not swap.
- Undefined: valid is unused; fetch and display proceed regardless of lock state.

Test Plan:
1. Reset, frame_base=0x1000 with an index pulse, rowChange with row=3 -> one-cycle ack; rd_req with rd_addr=0x1060; after rd_gnt and 32 words 0..31, row_ready pulses, disp_row=3, disp_addr=5 returns 5 one cycle later.
2. rowChange held for 4 cycles -> rowChangeAck is exactly one cycle long; only one fetch issued.
3. Requests for rows 7, 8, 9 during an in-flight burst for row 6 -> overrun=1; the next fetch is row 9 at base+0x120; row 8 is never fetched.
4. row=63, ROW_WORDS=32, base=0xFFFFF0 -> rd_addr=0x0007D0 (wraps); rd_req held high across 5 cycles with no grant and rd_addr stable.
5. Reset asserted after 10 of 32 words received -> all outputs return to reset values; the next request fetches normally and the stale valid beats are ignored.
6. With BLANK_ON_INVALID_EN defined, valid=0 -> disp_data=0 and a request is acked without a fetch; valid=1 -> the previous front-buffer data reappears.
